// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the three requester ports (fetch, load/store, debug) and
//           the single-port memory port served by mem_port_arbiter.
// Modports: slave  - arbiter side (requests/mem_rdata in; ready/rsp/mem out)
//           master - requester/memory side (mirror of slave)
// Signals : if_*  fetch read port       dm_*  load/store port
//           dbg_* debug read port       mem_* memory access port
//           rsp_rdata_o shared read data, busy_o transaction in flight
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned STRB_W = XLEN / 8;

    // fetch port
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_rsp_valid_o;

    // load/store port
    logic              dm_req_valid_i;
    logic              dm_req_ready_o;
    logic [XLEN-1:0]   dm_addr_i;
    logic              dm_we_i;
    logic [XLEN-1:0]   dm_wdata_i;
    logic [STRB_W-1:0] dm_wstrb_i;
    logic              dm_rsp_valid_o;

    // debug port
    logic              dbg_req_valid_i;
    logic              dbg_req_ready_o;
    logic [XLEN-1:0]   dbg_addr_i;
    logic              dbg_rsp_valid_o;

    // shared response data
    logic [XLEN-1:0]   rsp_rdata_o;

    // memory port
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic [XLEN-1:0]   mem_rdata_i;

    logic              busy_o;

    modport slave (
        input  if_req_valid_i, if_addr_i,
        input  dm_req_valid_i, dm_addr_i, dm_we_i, dm_wdata_i, dm_wstrb_i,
        input  dbg_req_valid_i, dbg_addr_i,
        input  mem_rdata_i,
        output if_req_ready_o, if_rsp_valid_o,
        output dm_req_ready_o, dm_rsp_valid_o,
        output dbg_req_ready_o, dbg_rsp_valid_o,
        output rsp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output busy_o
    );

    modport master (
        output if_req_valid_i, if_addr_i,
        output dm_req_valid_i, dm_addr_i, dm_we_i, dm_wdata_i, dm_wstrb_i,
        output dbg_req_valid_i, dbg_addr_i,
        output mem_rdata_i,
        input  if_req_ready_o, if_rsp_valid_o,
        input  dm_req_ready_o, dm_rsp_valid_o,
        input  dbg_req_ready_o, dbg_rsp_valid_o,
        input  rsp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : non-pipelined arbiter sharing one single-port memory between
//           instruction fetch, load/store unit and a debug read port.
//           One transaction in flight; read data returns MEM_LAT cycles after
//           the grant and is forwarded combinationally to the owner.
// Ports   : clk_i  - clock
//           rstn_i - asynchronous active-low reset
//           bus    - mem_port_arbiter_if.slave (requester + memory signals)
// Params  : XLEN    - address/data width
//           MEM_LAT - memory read latency in cycles, 1..15
module mem_port_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned    STRB_W   = XLEN / 8;
    localparam int unsigned    LAT_W    = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

    // Round-robin pointer between dm and if; names the preferred port.
    typedef enum logic {
        RR_DM = 1'b0,
        RR_IF = 1'b1
    } rr_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LAT_W-1:0]  r_lat;
    logic [LAT_W-1:0]  w_lat_nxt;
    rr_t               r_rr;
    rr_t               w_rr_nxt;
    owner_t            r_owner;
    owner_t            w_owner_nxt;

    logic              w_gnt_if;
    logic              w_gnt_dm;
    logic              w_gnt_dbg;
    logic              w_rsp_if;
    logic              w_rsp_dm;
    logic              w_rsp_dbg;
    logic [XLEN-1:0]   w_rsp_rdata;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [XLEN-1:0]   w_mem_addr;
    logic [XLEN-1:0]   w_mem_wdata;
    logic [STRB_W-1:0] w_mem_wstrb;
    logic              w_busy;

    // State, latency counter, round-robin pointer and owner registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_lat   <= '0;
            r_rr    <= RR_DM;
            r_owner <= OWN_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state, grant selection and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_gnt_if    = 1'b0;
        w_gnt_dm    = 1'b0;
        w_gnt_dbg   = 1'b0;
        w_rsp_if    = 1'b0;
        w_rsp_dm    = 1'b0;
        w_rsp_dbg   = 1'b0;
        w_rsp_rdata = '0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_wstrb = '0;
        w_busy      = 1'b0;

        case (r_state)
            IDLE: begin
                // Grants are gated by rstn_i so every output reads 0 while
                // reset is held, even with requests pending.
                if (rstn_i) begin
                    if (bus.dbg_req_valid_i) begin
                        w_gnt_dbg = 1'b1;
                    end else if (bus.dm_req_valid_i &&
                                 ((r_rr == RR_DM) || !bus.if_req_valid_i)) begin
                        w_gnt_dm = 1'b1;
                    end else if (bus.if_req_valid_i) begin
                        w_gnt_if = 1'b1;
                    end
                end

                if (w_gnt_dbg) begin
                    w_owner_nxt = OWN_DBG;
                    w_mem_addr  = bus.dbg_addr_i;
                end else if (w_gnt_dm) begin
                    w_owner_nxt = OWN_DM;
                    w_rr_nxt    = RR_IF;
                    w_mem_addr  = bus.dm_addr_i;
                    w_mem_we    = bus.dm_we_i;
                    w_mem_wdata = bus.dm_wdata_i;
                    w_mem_wstrb = bus.dm_wstrb_i;
                end else if (w_gnt_if) begin
                    w_owner_nxt = OWN_IF;
                    w_rr_nxt    = RR_DM;
                    w_mem_addr  = bus.if_addr_i;
                end

                if (w_gnt_dbg || w_gnt_dm || w_gnt_if) begin
                    w_mem_req   = 1'b1;
                    w_busy      = 1'b1;
                    w_lat_nxt   = LAT_LOAD;
                    w_state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
                end
            end

            WAIT: begin
                w_busy    = 1'b1;
                w_lat_nxt = r_lat - LAT_W'(1);
                // Counter reaching zero on this decrement means the data
                // arrives next cycle.
                if (r_lat <= LAT_W'(1)) begin
                    w_lat_nxt   = '0;
                    w_state_nxt = RESP;
                end
            end

            RESP: begin
                w_busy      = 1'b1;
                w_rsp_if    = (r_owner == OWN_IF);
                w_rsp_dm    = (r_owner == OWN_DM);
                w_rsp_dbg   = (r_owner == OWN_DBG);
                w_rsp_rdata = bus.mem_rdata_i;
                w_owner_nxt = OWN_NONE;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    assign bus.if_req_ready_o  = w_gnt_if;
    assign bus.dm_req_ready_o  = w_gnt_dm;
    assign bus.dbg_req_ready_o = w_gnt_dbg;
    assign bus.if_rsp_valid_o  = w_rsp_if;
    assign bus.dm_rsp_valid_o  = w_rsp_dm;
    assign bus.dbg_rsp_valid_o = w_rsp_dbg;
    assign bus.rsp_rdata_o     = w_rsp_rdata;
    assign bus.mem_req_o       = w_mem_req;
    assign bus.mem_we_o        = w_mem_we;
    assign bus.mem_addr_o      = w_mem_addr;
    assign bus.mem_wdata_o     = w_mem_wdata;
    assign bus.mem_wstrb_o     = w_mem_wstrb;
    assign bus.busy_o          = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter. A cycle-by-cycle vector
//           table drives a MEM_LAT=2 instance; hand-written sequences cover
//           MEM_LAT=1 throughput and a bounded wait for a debug response.
module tb_mem_port_arbiter;
    localparam int unsigned XLEN = 32;

    localparam logic [31:0] IF_A  = 32'h0000_0100;
    localparam logic [31:0] DM_A  = 32'h0000_2000;
    localparam logic [31:0] DBG_A = 32'h0000_3000;
    localparam logic [31:0] DM_WD = 32'hDEAD_BEEF;
    localparam logic [3:0]  DM_WS = 4'b0011;

    // port codes used for grant / response expectations
    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_IF   = 2'd1;
    localparam logic [1:0] P_DM   = 2'd2;
    localparam logic [1:0] P_DBG  = 2'd3;

    typedef struct {
        string       name;
        logic        rstn;
        logic        if_v;
        logic        dm_v;
        logic        dm_we;
        logic        dbg_v;
        logic [31:0] mrd;
        logic [1:0]  gnt;
        logic [1:0]  rsp;
        logic        busy;
    } vec_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.XLEN(XLEN)) a ();
    mem_port_arbiter_if #(.XLEN(XLEN)) b ();

    mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(2)) u_dut2 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (a)
    );

    mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(1)) u_dut1 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rstn_v, input logic if_v,
                                input logic dm_v, input logic dm_we, input logic dbg_v,
                                input logic [31:0] mrd, input logic [1:0] gnt,
                                input logic [1:0] rsp, input logic busy);
        vec_t v;
        v.name = name;  v.rstn = rstn_v; v.if_v = if_v; v.dm_v = dm_v;
        v.dm_we = dm_we; v.dbg_v = dbg_v; v.mrd = mrd; v.gnt = gnt;
        v.rsp = rsp; v.busy = busy;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] e_addr;
        logic        found;
        int          lat_cnt;

        checks   = 0;
        failures = 0;
        rstn     = 1'b0;

        a.if_req_valid_i  = 1'b0; a.if_addr_i  = IF_A;
        a.dm_req_valid_i  = 1'b0; a.dm_addr_i  = DM_A; a.dm_we_i = 1'b0;
        a.dm_wdata_i      = DM_WD; a.dm_wstrb_i = DM_WS;
        a.dbg_req_valid_i = 1'b0; a.dbg_addr_i = DBG_A;
        a.mem_rdata_i     = '0;
        b.if_req_valid_i  = 1'b0; b.if_addr_i  = IF_A;
        b.dm_req_valid_i  = 1'b0; b.dm_addr_i  = DM_A; b.dm_we_i = 1'b0;
        b.dm_wdata_i      = DM_WD; b.dm_wstrb_i = DM_WS;
        b.dbg_req_valid_i = 1'b0; b.dbg_addr_i = DBG_A;
        b.mem_rdata_i     = '0;

        //                 name         rstn if dm we dbg  mrd           gnt     rsp     busy
        vecs.push_back(mk("rst",         0, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 0));
        vecs.push_back(mk("rst_vld",     0, 1, 1, 0, 1, 32'h0,          P_NONE, P_NONE, 0));
        vecs.push_back(mk("f_gnt",       1, 1, 0, 0, 0, 32'h0,          P_IF,   P_NONE, 1));
        vecs.push_back(mk("f_wait",      1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("f_rsp",       1, 0, 0, 0, 0, 32'h0000_0013,  P_NONE, P_IF,   1));
        vecs.push_back(mk("f_idle",      1, 0, 0, 0, 0, 32'h0000_0013,  P_NONE, P_NONE, 0));
        vecs.push_back(mk("rr_rst",      0, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 0));
        vecs.push_back(mk("rr_g0",       1, 1, 1, 0, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("rr_w0",       1, 1, 1, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("rr_r0",       1, 1, 1, 0, 0, 32'h1111_1111,  P_NONE, P_DM,   1));
        vecs.push_back(mk("rr_g1",       1, 1, 1, 0, 0, 32'h0,          P_IF,   P_NONE, 1));
        vecs.push_back(mk("rr_w1",       1, 1, 1, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("rr_r1",       1, 1, 1, 0, 0, 32'h2222_2222,  P_NONE, P_IF,   1));
        vecs.push_back(mk("rr_g2",       1, 1, 1, 0, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("rr_w2",       1, 1, 1, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("rr_r2",       1, 1, 1, 0, 0, 32'h4444_4444,  P_NONE, P_DM,   1));
        vecs.push_back(mk("rr_g3",       1, 1, 1, 0, 0, 32'h0,          P_IF,   P_NONE, 1));
        vecs.push_back(mk("rr_w3",       1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("rr_r3",       1, 0, 0, 0, 0, 32'h7777_7777,  P_NONE, P_IF,   1));
        vecs.push_back(mk("dbg_g",       1, 1, 1, 0, 1, 32'h0,          P_DBG,  P_NONE, 1));
        vecs.push_back(mk("dbg_w",       1, 1, 1, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("dbg_r",       1, 1, 1, 0, 0, 32'h3333_3333,  P_NONE, P_DBG,  1));
        vecs.push_back(mk("dbg_dm_g",    1, 1, 1, 0, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("dbg_dm_w",    1, 1, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("dbg_dm_r",    1, 1, 0, 0, 0, 32'h1234_5678,  P_NONE, P_DM,   1));
        vecs.push_back(mk("dbg_if_g",    1, 1, 0, 0, 0, 32'h0,          P_IF,   P_NONE, 1));
        vecs.push_back(mk("dbg_if_w",    1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("dbg_if_r",    1, 0, 0, 0, 0, 32'h9ABC_DEF0,  P_NONE, P_IF,   1));
        vecs.push_back(mk("wr_g",        1, 0, 1, 1, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("wr_w",        1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("wr_r",        1, 0, 0, 0, 0, 32'h0,          P_NONE, P_DM,   1));
        vecs.push_back(mk("wr_idle",     1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 0));
        vecs.push_back(mk("rs_g",        1, 0, 1, 0, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("rs_rst",      0, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 0));
        vecs.push_back(mk("rs_rst2",     0, 0, 0, 0, 0, 32'h5555_5555,  P_NONE, P_NONE, 0));
        vecs.push_back(mk("rs_rel",      1, 0, 0, 0, 0, 32'h5555_5555,  P_NONE, P_NONE, 0));
        vecs.push_back(mk("rs_rel2",     1, 0, 0, 0, 0, 32'h5555_5555,  P_NONE, P_NONE, 0));
        vecs.push_back(mk("rs_g2",       1, 1, 1, 0, 0, 32'h0,          P_DM,   P_NONE, 1));
        vecs.push_back(mk("rs_w2_dbg",   1, 0, 0, 0, 1, 32'h0,          P_NONE, P_NONE, 1));
        vecs.push_back(mk("rs_r2",       1, 0, 0, 0, 0, 32'h6666_6666,  P_NONE, P_DM,   1));
        vecs.push_back(mk("rs_idle",     1, 0, 0, 0, 0, 32'h0,          P_NONE, P_NONE, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rstn              = vecs[i].rstn;
            a.if_req_valid_i  = vecs[i].if_v;
            a.dm_req_valid_i  = vecs[i].dm_v;
            a.dm_we_i         = vecs[i].dm_we;
            a.dbg_req_valid_i = vecs[i].dbg_v;
            a.mem_rdata_i     = vecs[i].mrd;
            @(negedge clk);
            e_addr = (vecs[i].gnt == P_IF)  ? IF_A  :
                     (vecs[i].gnt == P_DM)  ? DM_A  :
                     (vecs[i].gnt == P_DBG) ? DBG_A : 32'h0;
            chk({vecs[i].name, ".if_rdy"},  32'(a.if_req_ready_o),  32'(vecs[i].gnt == P_IF));
            chk({vecs[i].name, ".dm_rdy"},  32'(a.dm_req_ready_o),  32'(vecs[i].gnt == P_DM));
            chk({vecs[i].name, ".dbg_rdy"}, 32'(a.dbg_req_ready_o), 32'(vecs[i].gnt == P_DBG));
            chk({vecs[i].name, ".if_rsp"},  32'(a.if_rsp_valid_o),  32'(vecs[i].rsp == P_IF));
            chk({vecs[i].name, ".dm_rsp"},  32'(a.dm_rsp_valid_o),  32'(vecs[i].rsp == P_DM));
            chk({vecs[i].name, ".dbg_rsp"}, 32'(a.dbg_rsp_valid_o), 32'(vecs[i].rsp == P_DBG));
            chk({vecs[i].name, ".rdata"},   a.rsp_rdata_o,
                (vecs[i].rsp != P_NONE) ? vecs[i].mrd : 32'h0);
            chk({vecs[i].name, ".mem_req"}, 32'(a.mem_req_o),       32'(vecs[i].gnt != P_NONE));
            chk({vecs[i].name, ".mem_we"},  32'(a.mem_we_o),
                32'((vecs[i].gnt == P_DM) && vecs[i].dm_we));
            chk({vecs[i].name, ".mem_addr"}, a.mem_addr_o, e_addr);
            chk({vecs[i].name, ".mem_wdata"}, a.mem_wdata_o,
                (vecs[i].gnt == P_DM) ? DM_WD : 32'h0);
            chk({vecs[i].name, ".mem_wstrb"}, 32'(a.mem_wstrb_o),
                (vecs[i].gnt == P_DM) ? 32'(DM_WS) : 32'h0);
            chk({vecs[i].name, ".busy"},    32'(a.busy_o),          32'(vecs[i].busy));
            chk({vecs[i].name, ".b_busy"},  32'(b.busy_o),          32'h0);
        end

        // MEM_LAT=1: dm held valid -> grant every other cycle, ack in between
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            b.dm_req_valid_i = 1'b1;
            b.mem_rdata_i    = 32'hC0DE_0000 + 32'(c);
            @(negedge clk);
            chk($sformatf("lat1_c%0d.dm_rdy", c), 32'(b.dm_req_ready_o), 32'((c % 2) == 0));
            chk($sformatf("lat1_c%0d.mem_req", c), 32'(b.mem_req_o),     32'((c % 2) == 0));
            chk($sformatf("lat1_c%0d.dm_rsp", c), 32'(b.dm_rsp_valid_o), 32'((c % 2) == 1));
            chk($sformatf("lat1_c%0d.rdata", c),  b.rsp_rdata_o,
                ((c % 2) == 1) ? (32'hC0DE_0000 + 32'(c)) : 32'h0);
            chk($sformatf("lat1_c%0d.busy", c),   32'(b.busy_o),         32'h1);
        end
        @(posedge clk); #1;
        b.dm_req_valid_i = 1'b0;

        // Debug read on MEM_LAT=2 instance: bounded wait for the response
        a.dbg_req_valid_i = 1'b1;
        a.mem_rdata_i     = 32'hBEEF_0042;
        @(negedge clk);
        chk("dbgw.rdy", 32'(a.dbg_req_ready_o), 32'h1);
        chk("dbgw.addr", a.mem_addr_o, DBG_A);
        @(posedge clk); #1;
        a.dbg_req_valid_i = 1'b0;
        found   = 1'b0;
        lat_cnt = 1;
        for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk);
            if (a.dbg_rsp_valid_o) found = 1'b1;
            else begin
                @(posedge clk); #1;
                lat_cnt++;
            end
        end
        chk("dbgw.seen", 32'(found), 32'h1);
        chk("dbgw.latency", 32'(lat_cnt), 32'd2);
        chk("dbgw.rdata", a.rsp_rdata_o, 32'hBEEF_0042);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dbgw.pulse_end", 32'(a.dbg_rsp_valid_o), 32'h0);
        chk("dbgw.idle", 32'(a.busy_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory of the core between three requesters: instruction fetch (if_), load/store unit (dm_) and debug/bench inspection port (dbg_).
- Non-pipelined: one memory transaction in flight; fixed memory read latency counted internally.
- Sits between riscv core ports and the memory model; the debug port replaces ad-hoc bench peeking at memory.

Parameters:
XLEN, 32, address/data width (riscv_pkg::XLEN)
MEM_LAT, 2, cycles from accepted request to valid mem_rdata_i; legal range 1..15

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
if_req_valid_i  in  1  fetch read request
if_req_ready_o  out  1  fetch request accepted this cycle
if_addr_i  in  XLEN  fetch byte address
if_rsp_valid_o  out  1  fetch read data valid (1-cycle pulse)
dm_req_valid_i  in  1  load/store request
dm_req_ready_o  out  1  load/store request accepted
dm_addr_i  in  XLEN  load/store byte address
dm_we_i  in  1  1=write, 0=read
dm_wdata_i  in  XLEN  write data
dm_wstrb_i  in  XLEN/8  byte enables for writes
dm_rsp_valid_o  out  1  load data valid / store ack (1-cycle pulse)
dbg_req_valid_i  in  1  debug read request
dbg_req_ready_o  out  1  debug request accepted
dbg_addr_i  in  XLEN  debug byte address
dbg_rsp_valid_o  out  1  debug read data valid
rsp_rdata_o  out  XLEN  shared read data, valid with any *_rsp_valid_o
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  XLEN  memory address
mem_wdata_o  out  XLEN  memory write data
mem_wstrb_o  out  XLEN/8  memory byte enables
mem_rdata_i  in  XLEN  memory read data, valid MEM_LAT cycles after mem_req_o
busy_o  out  1  transaction in flight

Behaviour:
- Reset: state IDLE, lat counter 0, rr pointer = dm, owner = none; all *_ready_o, *_rsp_valid_o, mem_req_o, mem_we_o, busy_o = 0; mem_addr_o/wdata/wstrb = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, grant one in the same cycle (cycle T): ready_o of winner =1 (combinational from valid, only in IDLE); mem_req_o=1 with winner's addr/we/wdata/wstrb; fetch and debug drive we=0, wstrb=0. Record owner, load counter = MEM_LAT-1, go WAIT (MEM_LAT=1: go straight to RESP).
- Priority: dbg strict highest; between dm and if round-robin. rr pointer names the preferred port; after a dm or if grant it flips to the other. dbg grants leave it unchanged.
- WAIT: mem_req_o=0; decrement counter each cycle; at 0 go RESP. No grants, all ready_o=0.
- RESP (cycle T+MEM_LAT): owner's rsp_valid_o=1 for exactly one cycle; rsp_rdata_o = mem_rdata_i (combinational). Writes also pulse rsp_valid_o (ack); rsp_rdata_o then don't-care. Next cycle IDLE. No grant in RESP.
- rsp_rdata_o = 0 whenever no rsp_valid_o is high.
- Throughput: one transaction per MEM_LAT+1 cycles.
- busy_o = 1 in WAIT and RESP and in the IDLE grant cycle.
- Requesters hold valid and payload stable until ready; dropping valid before ready is legal (request discarded, no grant).
- Responses have no backpressure.
- Addresses passed unmodified; no alignment check.
- Async reset mid-transaction: immediate return to reset values; pending response is lost, never emitted after reset release.

Test Plan:
- MEM_LAT=2, if_req_valid at T, if_addr=0x100, mem_rdata_i=0x00000013 at T+2 -> if_req_ready_o and mem_req_o high at T only, mem_addr_o=0x100, if_rsp_valid_o one pulse at T+2 with rsp_rdata_o=0x00000013, busy_o high T..T+2.
- After reset, if and dm both continuously valid -> grant order dm, if, dm, if at cycles T, T+3, T+6, T+9; no grant in any other cycle.
- dbg, dm, if all valid at T -> dbg granted at T; dm at T+3 -> if at T+6 (rr unchanged by dbg).
- dm write addr 0x2000, wdata 0xDEADBEEF, wstrb 0b0011 -> mem_we_o=1, mem_wstrb_o=0b0011, mem_wdata_o=0xDEADBEEF at T; dm_rsp_valid_o pulse at T+2; if/dbg rsp_valid stay 0.
- rstn_i low at T+1 during dm read -> all outputs 0 immediately; no dm_rsp_valid_o ever for that read; after release, if and dm both valid -> dm granted first.
- MEM_LAT=1, dm valid continuously -> grants at T, T+2, T+4; dm_rsp_valid_o at T+1, T+3, T+5.
